// File: rtl/ppi_bus_controller.sv
// CPU-to-PPI bus sequencer: decodes the I/O address into slot and register,
// drives one-hot select with registered strobes, waits for ready with a timeout.
module ppi_bus_controller #(
  parameter int unsigned NUM_PPI  = 4,
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [31:0] ERR_DATA = 32'hBADC0FFE
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic [8:0]             AddressOutIO,
  input  logic [31:0]            DataOutputTowardIO,
  input  logic                   WritePPI,
  input  logic                   ReadPPI,
  output logic [31:0]            DataInputTowardMicro,
  output logic                   StallMicro,
  output logic                   BusError,
  output logic [NUM_PPI-1:0]     PPISelect,
  output logic [3:0]             PPIAddress,
  output logic [31:0]            PPIWriteData,
  output logic                   PPIWrite,
  output logic                   PPIRead,
  input  logic [32*NUM_PPI-1:0]  PPIReadData,
  input  logic [NUM_PPI-1:0]     PPIReady
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERROR} state_e;

  localparam logic [5:0] NumPpiC  = 6'(NUM_PPI);
  localparam logic [7:0] TimeoutC = 8'(TIMEOUT);

  state_e             state_q;
  logic [7:0]         cnt_q;
  logic [NUM_PPI-1:0] sel_q;
  logic [3:0]         addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic               wr_q;
  logic               rd_q;
  logic               err_q;

  logic               req;
  logic               slot_ok;
  logic               ready_sel;
  logic [7:0]         cnt_d;
  logic [NUM_PPI-1:0] sel_d;
  logic [31:0]        rdata_sel;

  assign req       = WritePPI | ReadPPI;
  assign slot_ok   = {1'b0, AddressOutIO[8:4]} < NumPpiC;
  assign cnt_d     = cnt_q + 8'd1;
  // sel_q is only non-zero in ACCESS, so ready from other slots never matters.
  assign ready_sel = |(PPIReady & sel_q);

  // NOTE: every variable in this block gets a default before the loop, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_d     = '0;
    rdata_sel = '0;
    for (int i = 0; i < NUM_PPI; i++) begin
      sel_d[i] = (AddressOutIO[8:4] == 5'(i));
      if (sel_q[i]) rdata_sel = PPIReadData[32*i +: 32];
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // sees pre-edge values regardless of statement order inside the block.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            addr_q  <= AddressOutIO[3:0];
            wdata_q <= DataOutputTowardIO;
            cnt_q   <= '0;
            if (slot_ok) begin
              state_q <= ACCESS;
              sel_q   <= sel_d;
              wr_q    <= WritePPI;
              rd_q    <= ~WritePPI;
            end else begin
              state_q <= ERROR;
              err_q   <= 1'b1;
              if (!WritePPI) rdata_q <= ERR_DATA;
            end
          end
        end
        ACCESS: begin
          cnt_q <= cnt_d;
          if (ready_sel) begin
            state_q <= DONE;
            sel_q   <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            if (rd_q) rdata_q <= rdata_sel;
          end else if (cnt_d == TimeoutC) begin
            state_q <= ERROR;
            err_q   <= 1'b1;
            sel_q   <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            if (rd_q) rdata_q <= ERR_DATA;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Gated by Reset so the CPU hold also drops the moment reset is asserted.
  assign StallMicro = Reset & (((state_q == IDLE) & req) | (state_q == ACCESS));

  assign DataInputTowardMicro = rdata_q;
  assign BusError             = err_q;
  assign PPISelect            = sel_q;
  assign PPIAddress           = addr_q;
  assign PPIWriteData         = wdata_q;
  assign PPIWrite             = wr_q;
  assign PPIRead              = rd_q;

endmodule

// File: tb/tb_ppi_bus_controller.sv
// Scoreboard bench for ppi_bus_controller: behavioural PPI devices, a
// transaction-level reference model, and an independent end-of-access monitor.
module tb_ppi_bus_controller;

  localparam int          NUM_PPI  = 4;
  localparam int          TIMEOUT  = 15;
  localparam logic [31:0] ERR_DATA = 32'hBADC0FFE;

  logic                  CLK = 1'b0;
  logic                  Reset = 1'b1;
  logic [8:0]            AddressOutIO = '0;
  logic [31:0]           DataOutputTowardIO = '0;
  logic                  WritePPI = 1'b0;
  logic                  ReadPPI = 1'b0;
  logic [31:0]           DataInputTowardMicro;
  logic                  StallMicro;
  logic                  BusError;
  logic [NUM_PPI-1:0]    PPISelect;
  logic [3:0]            PPIAddress;
  logic [31:0]           PPIWriteData;
  logic                  PPIWrite;
  logic                  PPIRead;
  logic [32*NUM_PPI-1:0] PPIReadData = '0;
  logic [NUM_PPI-1:0]    PPIReady = '0;

  always #5 CLK = ~CLK;

  ppi_bus_controller #(
    .NUM_PPI (NUM_PPI),
    .TIMEOUT (TIMEOUT),
    .ERR_DATA(ERR_DATA)
  ) dut (
    .CLK                 (CLK),
    .Reset               (Reset),
    .AddressOutIO        (AddressOutIO),
    .DataOutputTowardIO  (DataOutputTowardIO),
    .WritePPI            (WritePPI),
    .ReadPPI             (ReadPPI),
    .DataInputTowardMicro(DataInputTowardMicro),
    .StallMicro          (StallMicro),
    .BusError            (BusError),
    .PPISelect           (PPISelect),
    .PPIAddress          (PPIAddress),
    .PPIWriteData        (PPIWriteData),
    .PPIWrite            (PPIWrite),
    .PPIRead             (PPIRead),
    .PPIReadData         (PPIReadData),
    .PPIReady            (PPIReady)
  );

  typedef struct {
    logic               err;
    logic [31:0]        rdata;
    int                 acc;
    logic               write;
    logic [3:0]         addr;
    logic [31:0]        wdata;
    logic [NUM_PPI-1:0] sel;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          lat     [NUM_PPI];   // ready arrives in this ACCESS cycle; 0 = never
  logic [31:0] rd_data [NUM_PPI];
  logic [31:0] model_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  // Transaction-level expectation: outcome decided by slot range and device latency.
  function automatic exp_t model(input bit wr, input logic [8:0] a, input logic [31:0] wd);
    exp_t e;
    int   slot;
    slot    = int'(a[8:4]);
    e.write = wr;
    e.addr  = a[3:0];
    e.wdata = wd;
    e.sel   = '0;
    e.err   = 1'b0;
    e.acc   = 0;
    if (slot >= NUM_PPI) begin
      e.err = 1'b1;
    end else begin
      e.sel[slot] = 1'b1;
      if (lat[slot] != 0 && lat[slot] <= TIMEOUT) begin
        e.acc = lat[slot];
      end else begin
        e.acc = TIMEOUT;
        e.err = 1'b1;
      end
    end
    if (!wr) model_rdata = e.err ? ERR_DATA : rd_data[slot];
    e.rdata = model_rdata;
    return e;
  endfunction

  // PPI devices: ready after lat[k] selected cycles; unselected slots toggle randomly.
  initial begin
    int cyc [NUM_PPI];
    for (int k = 0; k < NUM_PPI; k++) cyc[k] = 0;
    forever begin
      @(negedge CLK);
      for (int k = 0; k < NUM_PPI; k++) begin
        PPIReadData[32*k +: 32] = rd_data[k];
        if (PPISelect[k]) begin
          cyc[k]++;
          PPIReady[k] = (lat[k] != 0) && (cyc[k] >= lat[k]);
        end else begin
          cyc[k]      = 0;
          PPIReady[k] = 1'($urandom);
        end
      end
    end
  end

  // Monitor: a falling StallMicro marks the end of one access.
  initial begin
    int                 acc, stall_n, err_n, wr_n, rd_n;
    bit                 prev_stall, hold_bad;
    logic [NUM_PPI-1:0] sel_seen;
    logic [3:0]         addr_seen;
    logic [31:0]        wdata_seen;
    exp_t               e;
    acc = 0; stall_n = 0; err_n = 0; wr_n = 0; rd_n = 0;
    prev_stall = 1'b0; hold_bad = 1'b0;
    sel_seen = '0; addr_seen = '0; wdata_seen = '0;
    forever begin
      @(negedge CLK);
      #1;
      if (!Reset) begin
        acc = 0; stall_n = 0; err_n = 0; wr_n = 0; rd_n = 0;
        prev_stall = 1'b0; hold_bad = 1'b0;
        continue;
      end
      if (PPISelect != '0) begin
        if (acc == 0) begin
          sel_seen   = PPISelect;
          addr_seen  = PPIAddress;
          wdata_seen = PPIWriteData;
        end else if (PPISelect !== sel_seen || PPIAddress !== addr_seen ||
                     PPIWriteData !== wdata_seen) begin
          hold_bad = 1'b1;
        end
        acc++;
      end
      wr_n    += int'(PPIWrite);
      rd_n    += int'(PPIRead);
      stall_n += int'(StallMicro);
      err_n   += int'(BusError);
      if (prev_stall && !StallMicro) begin
        if (sb_q.size() == 0) begin
          check("unexpected_access_end", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check("bus_error_cycles", 32'(err_n), 32'(e.err));
          check("read_data", DataInputTowardMicro, e.rdata);
          check("access_cycles", 32'(acc), 32'(e.acc));
          check("stall_cycles", 32'(stall_n), 32'(e.acc + 1));
          check("write_strobe_cycles", 32'(wr_n), 32'(e.write ? e.acc : 0));
          check("read_strobe_cycles", 32'(rd_n), 32'(e.write ? 0 : e.acc));
          if (e.acc > 0) begin
            check("select", 32'(sel_seen), 32'(e.sel));
            check("ppi_address", 32'(addr_seen), 32'(e.addr));
            check("ppi_write_data", wdata_seen, e.wdata);
            check("held_stable", 32'(hold_bad), 32'd0);
          end
        end
        acc = 0; stall_n = 0; err_n = 0; wr_n = 0; rd_n = 0;
        hold_bad = 1'b0;
      end
      prev_stall = StallMicro;
    end
  end

  // Called at a falling edge; returns at the falling edge of the DONE/ERROR cycle.
  task automatic run_txn(input bit wr, input bit rd, input logic [8:0] a, input logic [31:0] wd);
    bit seen;
    int guard;
    WritePPI           = wr;
    ReadPPI            = rd;
    AddressOutIO       = a;
    DataOutputTowardIO = wd;
    sb_q.push_back(model(wr, a, wd));
    #1 seen = StallMicro;
    guard = 0;
    forever begin
      @(negedge CLK);
      if (seen && !StallMicro) break;
      if (seen && StallMicro) begin
        AddressOutIO       = 9'($urandom);
        DataOutputTowardIO = $urandom;
      end
      if (StallMicro) seen = 1'b1;
      guard++;
      if (guard > 100) begin
        n_checks++;
        $display("FAIL txn_end_wait: actual=no StallMicro fall in %0d cycles required=fall", guard);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    WritePPI = 1'b0;
    ReadPPI  = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdata"}, DataInputTowardMicro, 32'd0);
    check({tag, "_stall"}, 32'(StallMicro), 32'd0);
    check({tag, "_bus_error"}, 32'(BusError), 32'd0);
    check({tag, "_select"}, 32'(PPISelect), 32'd0);
    check({tag, "_address"}, 32'(PPIAddress), 32'd0);
    check({tag, "_write_data"}, PPIWriteData, 32'd0);
    check({tag, "_write"}, 32'(PPIWrite), 32'd0);
    check({tag, "_read"}, 32'(PPIRead), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < NUM_PPI; k++) begin
      lat[k]     = 1;
      rd_data[k] = $urandom;
    end
    #2 Reset = 1'b0;
    #1 check_all_zero("reset");
    @(negedge CLK);
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);

    // Zero-wait write to slot 1.
    lat[1] = 1;
    run_txn(1'b1, 1'b0, 9'h012, 32'hA5A5_0001);
    idle(2);
    // Read with three wait cycles from slot 3.
    lat[3]     = 3;
    rd_data[3] = 32'hCAFE_1234;
    run_txn(1'b0, 1'b1, 9'h035, $urandom);
    idle(2);
    // Out-of-range slot.
    run_txn(1'b0, 1'b1, 9'h1F0, 32'd0);
    idle(2);
    // Write that never sees ready.
    lat[2] = 0;
    run_txn(1'b1, 1'b0, 9'h020, 32'h0000_1234);
    idle(2);
    // Write+read together, then back-to-back requests held through DONE.
    lat[0] = 2;
    run_txn(1'b1, 1'b1, 9'h007, 32'h0000_0077);
    lat[3] = 1;
    run_txn(1'b0, 1'b1, 9'h03A, 32'h0BAD_F00D);
    run_txn(1'b1, 1'b0, 9'h011, 32'h1111_2222);
    idle(2);

    // Reset while a read is waiting on a device that never answers.
    lat[0]       = 0;
    AddressOutIO = 9'h004;
    ReadPPI      = 1'b1;
    repeat (4) @(negedge CLK);
    #2 Reset = 1'b0;
    #1 check_all_zero("abort");
    model_rdata = '0;
    @(negedge CLK);
    ReadPPI = 1'b0;
    @(negedge CLK);
    #2 Reset = 1'b1;
    @(negedge CLK);
    lat[0]     = 2;
    rd_data[0] = 32'h1357_9BDF;
    run_txn(1'b0, 1'b1, 9'h00C, $urandom);
    idle(2);

    repeat (60) begin
      int         s;
      bit         w, r;
      logic [8:0] a;
      for (int k = 0; k < NUM_PPI; k++) begin
        if ($urandom_range(0, 7) == 0) lat[k] = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(16, 20);
        else lat[k] = $urandom_range(1, 5);
        rd_data[k] = $urandom;
      end
      s = $urandom_range(0, 5);
      if (s >= NUM_PPI) s = $urandom_range(NUM_PPI, 31);
      a = {5'(s), 4'($urandom)};
      w = 1'($urandom);
      r = w ? 1'($urandom) : 1'b1;
      run_txn(w, r, a, $urandom);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 3));
    end
    idle(5);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ppi_bus_controller.md
Name: ppi_bus_controller

Overview:
- Sequences every CPU I/O access onto the PPI peripheral bus.
- Decodes the 9-bit I/O address into a PPI slot and a local register address.
- Drives one-hot select and registered strobes to the selected PPI, and waits for that PPI's ready.
- Returns read data on DataInputTowardMicro, stalls the CPU for the duration, and raises a bus error on a bad slot or a timeout.

Parameters:
- NUM_PPI, 4, number of attached PPIs (1..32); slot index = AddressOutIO[8:4].
- TIMEOUT, 15, maximum ACCESS cycles without ready before the error path (1..255).
- ERR_DATA, 32'hBADC0FFE, read data returned on error.

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset (Reset=0 resets).
- AddressOutIO  in  9  CPU I/O address; [8:4] slot, [3:0] local register.
- DataOutputTowardIO  in  32  CPU write data.
- WritePPI  in  1  CPU write request (level).
- ReadPPI  in  1  CPU read request (level).
- DataInputTowardMicro  out  32  registered read data to the CPU.
- StallMicro  out  1  CPU hold.
- BusError  out  1  one-cycle error pulse.
- PPISelect  out  NUM_PPI  one-hot PPI select.
- PPIAddress  out  4  latched local address.
- PPIWriteData  out  32  latched write data.
- PPIWrite  out  1  write strobe.
- PPIRead  out  1  read strobe.
- PPIReadData  in  32*NUM_PPI  concatenated PPI read buses; slot k occupies [32k+31:32k].
- PPIReady  in  NUM_PPI  per-PPI completion.

Behaviour:
- Reset (asynchronous, Reset=0), all outputs zero:
  - State=IDLE, timeout counter=0, latches cleared.
  - DataInputTowardMicro=0, StallMicro=0, BusError=0, PPISelect=0, PPIAddress=0, PPIWriteData=0, PPIWrite=0, PPIRead=0.
- Reset asserted mid-transaction: same result immediately. The transaction is aborted, with no ready wait and no error pulse.
- States: IDLE, ACCESS, DONE, ERROR. Encoding is free.
- IDLE:
  - A request is WritePPI|ReadPPI sampled high; if both are high, write wins.
  - On a request, latch address, data and direction.
  - Slot < NUM_PPI → ACCESS; otherwise → ERROR.
- ACCESS:
  - PPISelect = one-hot(latched slot). PPIWrite or PPIRead is held high per direction. PPIAddress and PPIWriteData hold the latched values.
  - The counter increments each cycle.
  - PPIReady[slot] high → DONE. A read also loads DataInputTowardMicro from the slot's PPIReadData slice on that same edge.
  - Counter reaches TIMEOUT with ready low → ERROR.
  - Ready from unselected slots is ignored.
- DONE: one cycle. Strobes and select go low, counter clears, → IDLE.
- ERROR: one cycle.
  - BusError=1, strobes and select go low.
  - For a read, DataInputTowardMicro=ERR_DATA; for a write, DataInputTowardMicro is unchanged.
  - → IDLE.
- StallMicro (combinational):
  - High when (state==IDLE and a request is present) or state==ACCESS.
  - Low in DONE, ERROR, and in IDLE with no request.
- Handshake:
  - The CPU holds its request until StallMicro falls, then drops it.
  - A request still high in the following IDLE cycle starts a new transaction. There is no edge detection.
  - Requests and input changes during ACCESS, DONE or ERROR are ignored; only the IDLE-sampled values are used.
- DataInputTowardMicro holds its value between reads.
- Latency: request sampled at edge N, ACCESS during N+1. If ready is high in the first ACCESS cycle, DONE during N+2 and IDLE at N+3. Minimum 3 cycles per access.
- Timeout: with TIMEOUT=T and ready never asserted, ERROR occurs exactly T ACCESS cycles after entry.

Test Plan:
- Write, zero-wait: Reset released; WritePPI=1, AddressOutIO=9'h012, DataOutputTowardIO=32'hA5A5_0001; PPIReady[1]=1 → exactly one ACCESS cycle with PPISelect=4'b0010, PPIAddress=4'h2, PPIWrite=1, PPIWriteData=32'hA5A5_0001; StallMicro low at DONE; BusError stays 0.
- Read with wait states: ReadPPI=1, address 9'h035, PPIReadData slot 3=32'hCAFE_1234, PPIReady[3] rises after 3 ACCESS cycles → PPIRead high for 3 cycles, DataInputTowardMicro=32'hCAFE_1234 at DONE, StallMicro high for 4 cycles total.
- Bad slot: ReadPPI=1, address 9'h1F0 → ERROR one cycle after the request, BusError pulse of 1 cycle, DataInputTowardMicro=32'hBADC0FFE, PPISelect never asserted.
- Timeout: WritePPI=1 to slot 2, PPIReady=0 → exactly 15 ACCESS cycles, then BusError=1, PPIWrite drops, DataInputTowardMicro unchanged, StallMicro falls.
- Simultaneous and back-to-back: WritePPI=ReadPPI=1 → a write is performed. Requests held high through DONE → a second transaction starts in the next IDLE cycle. PPIReady asserted on an unselected slot → ignored.
- Reset mid-ACCESS: Reset=0 during a read wait → all outputs 0 asynchronously, before the next CLK edge, and no BusError. After release, a new read completes normally.
